// File: rtl/dmem_ctrl.sv
// Data-memory controller: RISC-V load/store sizing on a word-wide byte-lane RAM with fixed wait states.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them down.
module dmem_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_SIZE    = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(NBYTES);
    localparam int IDX_W  = $clog2(MEM_SIZE);
    localparam int SH_W   = OFF_W + 3;
    localparam logic [3:0] WS_LAST = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_wait_cnt;
    logic                  w_accept;
    logic                  w_enter_resp;

    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [OFF_W-1:0]      r_off;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_legal;
    logic                  w_misalign;
    logic                  w_err;
    logic [OFF_W-1:0]      w_size_mask;
    logic [OFF_W-1:0]      w_aoff;
    logic [SH_W-1:0]       w_shift;
    logic [NBYTES-1:0]     w_be_base;
    logic [NBYTES-1:0]     w_be;
    logic [DATA_WIDTH-1:0] w_wdata_sh;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic                  r_rsp_load;
    logic                  r_rsp_err;
    logic [2:0]            r_rsp_f3;
    logic [SH_W-1:0]       r_rsp_shift;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_msb_mask;
    logic [6:0]            w_nbits;
    logic                  w_sign;

    assign req_ready    = (r_state == S_IDLE);
    assign resp_valid   = (r_state == S_RESP);
    assign w_accept     = req_valid && req_ready && !rst;
    assign w_enter_resp = (w_state_next == S_RESP) && (r_state != S_RESP) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (r_wait_cnt == WS_LAST) w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_off    <= req_addr[OFF_W-1:0];
            r_idx    <= req_addr[OFF_W +: IDX_W];
            r_wdata  <= req_wdata;
        end
    end

    // Address bits above the array depth are ignored so the address wraps.
    if (ADDR_WIDTH > OFF_W + IDX_W) begin : g_addr_hi
        logic w_addr_unused;
        assign w_addr_unused = ^req_addr[ADDR_WIDTH-1:OFF_W+IDX_W];
    end

    always_comb begin
        w_legal = 1'b0;
        unique case (r_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !r_we;
            3'b011:                 w_legal = (DATA_WIDTH == 64);
            3'b110:                 w_legal = (DATA_WIDTH == 64) && !r_we;
            default:                w_legal = 1'b0;
        endcase
        w_size_mask = OFF_W'((1 << r_funct3[1:0]) - 1);
        w_misalign  = |(r_off & w_size_mask);
        w_aoff      = r_off & ~w_size_mask;
`ifdef DMEM_MISALIGN_TRAP_EN
        w_err       = !w_legal || w_misalign;
`else
        w_err       = !w_legal;
`endif
        w_shift     = {w_aoff, 3'b000};
        unique case (r_funct3[1:0])
            2'd0:    w_be_base = NBYTES'(8'h01);
            2'd1:    w_be_base = NBYTES'(8'h03);
            2'd2:    w_be_base = NBYTES'(8'h0F);
            default: w_be_base = NBYTES'(8'hFF);
        endcase
        w_be       = w_be_base << w_aoff;
        w_wdata_sh = r_wdata << w_shift;
    end

    // One narrow RAM per byte lane gives byte-enable writes with a registered read.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
        logic [7:0] r_lane [MEM_SIZE] = '{default: 8'h00};
        logic [7:0] r_rd_byte;
        always_ff @(posedge clk) begin
            if (w_enter_resp) begin
                if (r_we && !w_err && w_be[gi]) begin
                    r_lane[r_idx] <= w_wdata_sh[gi*8 +: 8];
                end
                r_rd_byte <= r_lane[r_idx];
            end
        end
        assign w_rd_word[gi*8 +: 8] = r_rd_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_load  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_f3    <= 3'd0;
            r_rsp_shift <= '0;
        end else if (w_enter_resp) begin
            r_rsp_load  <= !r_we && !w_err;
            r_rsp_err   <= w_err;
            r_rsp_f3    <= r_funct3;
            r_rsp_shift <= w_shift;
        end
    end

    // Extraction works only on registered state, so the result holds until the next response.
    always_comb begin
        w_shifted  = w_rd_word >> r_rsp_shift;
        w_nbits    = 7'd8 << r_rsp_f3[1:0];
        w_mask     = ~({DATA_WIDTH{1'b1}} << w_nbits);
        w_msb_mask = w_mask ^ (w_mask >> 1);
        w_sign     = !r_rsp_f3[2] && |(w_shifted & w_msb_mask);
        resp_rdata = '0;
        if (r_rsp_load) begin
            resp_rdata = (w_shifted & w_mask) | (w_sign ? ~w_mask : '0);
        end
    end

    assign resp_err = r_rsp_err;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench: a 32-bit controller (WAIT_STATES=1) and a 64-bit one (WAIT_STATES=3) share stimulus.
`timescale 1ns/1ps
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_a = 1'b0;
    logic        req_valid_b = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        req_ready_a, req_ready_b;
    logic        resp_valid_a, resp_valid_b;
    logic [31:0] resp_rdata_a;
    logic [63:0] resp_rdata_b;
    logic        resp_err_a, resp_err_b;
    logic        cur_sel = 1'b0;
    logic        w_resp_valid;
    logic [63:0] w_rdata;
    logic        w_err;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(64), .WAIT_STATES(1)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .resp_valid(resp_valid_a),
        .resp_rdata(resp_rdata_a), .resp_err(resp_err_a)
    );

    dmem_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .MEM_SIZE(64), .WAIT_STATES(3)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid_b),
        .resp_rdata(resp_rdata_b), .resp_err(resp_err_b)
    );

    assign w_resp_valid = cur_sel ? resp_valid_b : resp_valid_a;
    assign w_rdata      = cur_sel ? resp_rdata_b : {32'h0, resp_rdata_a};
    assign w_err        = cur_sel ? resp_err_b : resp_err_a;

    // Issue one request and wait (bounded) for its response; lat = -1 on timeout.
    task automatic do_req(input logic sel, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [63:0] wd,
                          output logic [63:0] rd, output logic er, output int lat);
        @(negedge clk);
        cur_sel    = sel;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        lat = -1;
        rd  = 64'd0;
        er  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (w_resp_valid) begin
                lat = i;
                rd  = w_rdata;
                er  = w_err;
                break;
            end
        end
        $display("txn dut=%0d we=%0d f3=%0d addr=0x%08h wdata=0x%016h -> rdata=0x%016h err=%0d lat=%0d",
                 sel, we, f3, addr, wd, rd, er, lat);
    endtask

    task automatic test_reset();
        logic [63:0] rd;
        logic        er;
        int          lat;
        int          seen;
        rst = 1'b1;
        req_valid_a = 1'b1;
        req_valid_b = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'b010;
        req_addr = 32'h40;
        req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        @(negedge clk);
        total++;
        if ({req_ready_a, resp_valid_a, resp_rdata_a, resp_err_a} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_a: ready=%0d valid=%0d rdata=0x%08h err=%0d, required 1 0 0x0 0",
                     req_ready_a, resp_valid_a, resp_rdata_a, resp_err_a);
        end
        total++;
        if ({req_ready_b, resp_valid_b, resp_rdata_b, resp_err_b} !== {1'b1, 1'b0, 64'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_b: ready=%0d valid=%0d rdata=0x%016h err=%0d, required 1 0 0x0 0",
                     req_ready_b, resp_valid_b, resp_rdata_b, resp_err_b);
        end
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            seen += int'(resp_valid_a) + int'(resp_valid_b);
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL reset_ignore_valid: responses=%0d, required 0", seen);
        end
        do_req(1'b0, 1'b0, 3'b010, 32'h40, 64'd0, rd, er, lat);
        total++;
        if ({rd, er} !== {64'h0, 1'b0}) begin
            bad++;
            $display("FAIL zero_init: rdata=0x%016h err=%0d, required 0x0 0", rd, er);
        end
    endtask

    task automatic test_store_load();
        logic [63:0] rd;
        logic        er;
        int          lat;
        do_req(1'b0, 1'b1, 3'b010, 32'h10, 64'hDEAD_BEEF, rd, er, lat);
        total++;
        if ({lat, rd, er} !== {32'd2, 64'h0, 1'b0}) begin
            bad++;
            $display("FAIL sw_resp: lat=%0d rdata=0x%016h err=%0d, required 2 0x0 0", lat, rd, er);
        end
        do_req(1'b0, 1'b0, 3'b010, 32'h10, 64'd0, rd, er, lat);
        total++;
        if ({lat, rd, er} !== {32'd2, 64'hDEAD_BEEF, 1'b0}) begin
            bad++;
            $display("FAIL lw_resp: lat=%0d rdata=0x%016h err=%0d, required 2 0xdeadbeef 0", lat, rd, er);
        end
        repeat (2) @(negedge clk);
        total++;
        if ({resp_valid_a, resp_rdata_a} !== {1'b0, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL resp_hold: valid=%0d rdata=0x%08h, required 0 0xdeadbeef", resp_valid_a, resp_rdata_a);
        end
    endtask

    task automatic test_subword();
        logic [63:0] rd;
        logic        er;
        int          lat;
        logic [2:0]  f3s [5]  = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010};
        logic [31:0] adrs [5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
        logic [63:0] exps [5] = '{64'hFFFF_FFDE, 64'h0000_00DE, 64'h0000_DEAD, 64'hFFFF_DEAD, 64'hDEAD_BEEF};
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, 1'b0, f3s[i], adrs[i], 64'd0, rd, er, lat);
            total++;
            if ({rd, er} !== {exps[i], 1'b0}) begin
                bad++;
                $display("FAIL subword_load_%0d: rdata=0x%016h err=%0d, required 0x%016h 0", i, rd, er, exps[i]);
            end
        end
        do_req(1'b0, 1'b1, 3'b000, 32'h11, 64'hAAAA_AA55, rd, er, lat);
        do_req(1'b0, 1'b0, 3'b010, 32'h10, 64'd0, rd, er, lat);
        total++;
        if ({rd, er} !== {64'hDEAD_55EF, 1'b0}) begin
            bad++;
            $display("FAIL sb_merge: rdata=0x%016h err=%0d, required 0xdead55ef 0", rd, er);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] rd;
        logic        er;
        int          lat;
        do_req(1'b0, 1'b1, 3'b010, 32'h100, 64'h1234_5678, rd, er, lat);
        do_req(1'b0, 1'b0, 3'b010, 32'h0, 64'd0, rd, er, lat);
        total++;
        if ({rd, er} !== {64'h1234_5678, 1'b0}) begin
            bad++;
            $display("FAIL addr_wrap: rdata=0x%016h err=%0d, required 0x12345678 0", rd, er);
        end
    endtask

    task automatic test_misalign();
        logic [63:0] rd;
        logic        er;
        int          lat;
        logic [63:0] exp_lh, exp_lw, exp_w14;
        logic        exp_er;
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_lh = 64'h0; exp_lw = 64'h0; exp_w14 = 64'h0; exp_er = 1'b1;
`else
        exp_lh = 64'h55EF; exp_lw = 64'hDEAD_55EF; exp_w14 = 64'hBEEF; exp_er = 1'b0;
`endif
        do_req(1'b0, 1'b0, 3'b001, 32'h11, 64'd0, rd, er, lat);
        total++;
        if ({rd, er} !== {exp_lh, exp_er}) begin
            bad++;
            $display("FAIL misalign_lh: rdata=0x%016h err=%0d, required 0x%016h %0d", rd, er, exp_lh, exp_er);
        end
        do_req(1'b0, 1'b0, 3'b010, 32'h13, 64'd0, rd, er, lat);
        total++;
        if ({rd, er} !== {exp_lw, exp_er}) begin
            bad++;
            $display("FAIL misalign_lw: rdata=0x%016h err=%0d, required 0x%016h %0d", rd, er, exp_lw, exp_er);
        end
        do_req(1'b0, 1'b1, 3'b001, 32'h15, 64'hBEEF, rd, er, lat);
        do_req(1'b0, 1'b0, 3'b010, 32'h14, 64'd0, rd, er, lat);
        total++;
        if ({rd, er} !== {exp_w14, 1'b0}) begin
            bad++;
            $display("FAIL misalign_sh: rdata=0x%016h err=%0d, required 0x%016h 0", rd, er, exp_w14);
        end
    endtask

    task automatic test_illegal();
        logic [63:0] rd;
        logic        er;
        int          lat;
        logic        wes [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0]  f3s [5] = '{3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, wes[i], f3s[i], 32'h10, 64'h0, rd, er, lat);
            total++;
            if ({rd, er} !== {64'h0, 1'b1}) begin
                bad++;
                $display("FAIL illegal_%0d: rdata=0x%016h err=%0d, required 0x0 1", i, rd, er);
            end
        end
        do_req(1'b0, 1'b0, 3'b010, 32'h10, 64'd0, rd, er, lat);
        total++;
        if ({rd, er} !== {64'hDEAD_55EF, 1'b0}) begin
            bad++;
            $display("FAIL illegal_nowrite: rdata=0x%016h err=%0d, required 0xdead55ef 0", rd, er);
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0, rsp = 0, both = 0;
        @(negedge clk);
        cur_sel = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'b010;
        req_addr = 32'h10;
        req_valid_a = 1'b1;
        #1;
        for (int i = 0; i < 9; i++) begin
            acc  += int'(req_ready_a);
            rsp  += int'(resp_valid_a);
            both += int'(req_ready_a && resp_valid_a);
            @(negedge clk);
            #1;
        end
        req_valid_a = 1'b0;
        $display("txn back_to_back accepts=%0d responses=%0d overlap=%0d rdata=0x%08h", acc, rsp, both, resp_rdata_a);
        total++;
        if ({acc, rsp, both} !== {32'd3, 32'd3, 32'd0}) begin
            bad++;
            $display("FAIL back_to_back: accepts=%0d responses=%0d overlap=%0d, required 3 3 0", acc, rsp, both);
        end
        @(negedge clk);
    endtask

    task automatic test_dw64();
        logic [63:0] rd;
        logic        er;
        int          lat;
        logic [2:0]  f3s [5]  = '{3'b010, 3'b110, 3'b011, 3'b000, 3'b001};
        logic [31:0] adrs [5] = '{32'hC, 32'hC, 32'h8, 32'h8, 32'hE};
        logic [63:0] exps [5] = '{64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000,
                                  64'h8000_0000_0000_0001, 64'h1, 64'hFFFF_FFFF_FFFF_8000};
        do_req(1'b1, 1'b1, 3'b011, 32'h8, 64'h8000_0000_0000_0001, rd, er, lat);
        total++;
        if ({lat, rd, er} !== {32'd4, 64'h0, 1'b0}) begin
            bad++;
            $display("FAIL sd_resp: lat=%0d rdata=0x%016h err=%0d, required 4 0x0 0", lat, rd, er);
        end
        for (int i = 0; i < 5; i++) begin
            do_req(1'b1, 1'b0, f3s[i], adrs[i], 64'd0, rd, er, lat);
            total++;
            if ({rd, er} !== {exps[i], 1'b0}) begin
                bad++;
                $display("FAIL dw64_load_%0d: rdata=0x%016h err=%0d, required 0x%016h 0", i, rd, er, exps[i]);
            end
        end
    endtask

    task automatic test_abort();
        logic [63:0] rd;
        logic        er;
        int          lat;
        int          seen = 0;
        do_req(1'b1, 1'b1, 3'b010, 32'h20, 64'h1357_2468, rd, er, lat);
        @(negedge clk);
        cur_sel = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'b010;
        req_addr = 32'h20;
        req_wdata = 64'h0BAD_BEEF;
        req_valid_b = 1'b1;
        @(posedge clk);
        #1;
        req_valid_b = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({req_ready_b, resp_rdata_b, resp_err_b} !== {1'b1, 64'h0, 1'b0}) begin
            bad++;
            $display("FAIL abort_state: ready=%0d rdata=0x%016h err=%0d, required 1 0x0 0",
                     req_ready_b, resp_rdata_b, resp_err_b);
        end
        repeat (6) begin
            seen += int'(resp_valid_b);
            @(negedge clk);
        end
        $display("txn abort responses_after_reset=%0d", seen);
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL abort_no_resp: responses=%0d, required 0", seen);
        end
        do_req(1'b1, 1'b0, 3'b010, 32'h20, 64'd0, rd, er, lat);
        total++;
        if ({rd, er} !== {64'h1357_2468, 1'b0}) begin
            bad++;
            $display("FAIL abort_no_write: rdata=0x%016h err=%0d, required 0x13572468 0", rd, er);
        end
        do_req(1'b0, 1'b0, 3'b010, 32'h10, 64'd0, rd, er, lat);
        total++;
        if ({rd, er} !== {64'hDEAD_55EF, 1'b0}) begin
            bad++;
            $display("FAIL mem_survives_rst: rdata=0x%016h err=%0d, required 0xdead55ef 0", rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_subword();
        test_wrap();
        test_misalign();
        test_illegal();
        test_back_to_back();
        test_dw64();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter MEM_SIZE, default 64, depth in words; power of two.
REQ-004 SHALL have parameter WAIT_STATES, default 1, extra access cycles; range 0..15.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1 bit, reset; synchronous and active-high.
REQ-007 SHALL have port req_valid, input, 1 bit, request present.
REQ-008 SHALL have port req_ready, output, 1 bit, block can accept a request.
REQ-009 SHALL have port req_we, input, 1 bit, 1 = store, 0 = load.
REQ-010 SHALL have port req_funct3, input, 3 bits, RISC-V load/store funct3.
REQ-011 SHALL have port req_addr, input, ADDR_WIDTH bits, byte address.
REQ-012 SHALL have port req_wdata, input, DATA_WIDTH bits, store data, LSB-aligned.
REQ-013 SHALL have port resp_valid, output, 1 bit, one-cycle response strobe.
REQ-014 SHALL have port resp_rdata, output, DATA_WIDTH bits, extended load data.
REQ-015 SHALL have port resp_err, output, 1 bit, access faulted.

Function
REQ-016 SHALL accept a request on a rising edge where req_valid && req_ready, latching we/funct3/addr/wdata.
REQ-017 SHALL implement FSM IDLE/WAIT/RESP: IDLE -> WAIT on accept (WAIT_STATES>0) or -> RESP (WAIT_STATES=0); WAIT counts WAIT_STATES cycles -> RESP; RESP -> IDLE after one cycle.
REQ-018 SHALL assert req_ready only in IDLE; max throughput one request per WAIT_STATES+2 cycles.
REQ-019 SHALL assert resp_valid for exactly one cycle, in RESP, WAIT_STATES+1 cycles after the accept edge.
REQ-020 SHALL form the word index from address bits above log2(DATA_WIDTH/8); bits beyond log2(MEM_SIZE) ignored (address wraps).
REQ-021 SHALL support funct3 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu; DATA_WIDTH=64 adds 011 ld/sd and 110 lwu.
REQ-022 SHALL sign-extend lb/lh/lw(64-bit) and zero-extend lbu/lhu/lwu to DATA_WIDTH.
REQ-023 SHALL update only the addressed bytes on a store, on the edge entering RESP; other bytes unchanged.
REQ-024 SHALL sample array data for a load on the edge entering RESP; resp_rdata, resp_err registered.
REQ-025 SHALL hold resp_rdata/resp_err stable from RESP until the next RESP; resp_rdata = 0 for stores and errors.
REQ-026 SHALL treat unsupported funct3 (incl. store with 100/101/110) as error: resp_err=1, no write.
REQ-027 SHALL initialise array to zero at time zero; array not cleared by rst.

Reset
REQ-028 SHALL, while rst=1 at an edge, enter IDLE, clear wait counter, drive req_ready=1 after reset, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-029 SHALL abort an in-flight request on rst; a store not yet at its RESP edge SHALL NOT modify memory.
REQ-030 SHALL ignore req_valid in the cycle rst is asserted.

Configuration
REQ-031 SHALL honour macro DMEM_MISALIGN_TRAP_EN: when defined, an access not naturally aligned (halfword odd, word not ×4, doubleword not ×8) returns resp_err=1, resp_rdata=0, no write.
REQ-032 SHALL, without DMEM_MISALIGN_TRAP_EN, align misaligned addresses down to the access size, complete normally, resp_err=0.

Verification
REQ-033 WAIT_STATES=1: sw 0xDEADBEEF @0x10, then lw @0x10 -> each resp_valid 2 cycles after accept, lw rdata 0xDEADBEEF, err 0.
REQ-034 After 0xDEADBEEF @0x10: lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE; lhu @0x12 -> 0x0000DEAD; sb 0x55 @0x11 then lw @0x10 -> 0xDEAD55EF.
REQ-035 MEM_SIZE=64, DATA_WIDTH=32: sw 0x12345678 @0x100, lw @0x0 -> 0x12345678 (wrap).
REQ-036 lh @0x11: with DMEM_MISALIGN_TRAP_EN -> err 1, rdata 0; without -> reads halfword @0x10, err 0.
REQ-037 Accept sw @0x20 (WAIT_STATES=3), assert rst one cycle later -> no resp_valid, lw @0x20 -> prior value, req_ready=1 after reset.
REQ-038 DATA_WIDTH=64: sd 0x8000000000000001 @0x8, lw @0xC -> 0xFFFFFFFF80000000, lwu @0xC -> 0x0000000080000000.
